// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage of the 16-bit CPU.
//   DATA_WIDTH / ADDRESS_WIDTH : instruction and PC widths
//   RESET_PC                   : first fetch address after reset
//   NOP_INSTR                  : value shown on instr_o while nothing has been fetched
//   fetch_out_t                : {instr, pc, valid} bundle presented to decode
//   fetch_action_t             : the one thing the fetch stage does in a given cycle
package instruction_fetch_pkg;

  localparam int unsigned DATA_WIDTH    = 16;
  localparam int unsigned ADDRESS_WIDTH = 8;

  localparam logic [ADDRESS_WIDTH-1:0] RESET_PC  = 8'h00;
  localparam logic [DATA_WIDTH-1:0]    NOP_INSTR = '0;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     valid;
  } fetch_out_t;

  // Ordered by priority: hold beats redirect beats stall beats advance.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_REDIRECT,
    ACT_STALL,
    ACT_ADVANCE
  } fetch_action_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Signal bundle around the fetch stage: control from the pipeline/loader,
// the instruction-memory read port, and the instruction handed to decode.
//   master : the fetch stage (drives im_addr_o and the instr_* outputs)
//   slave  : the surrounding pipeline and memory
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic                     hold_i;
  logic                     stall_i;
  logic                     redirect_i;
  logic [ADDRESS_WIDTH-1:0] redirect_pc_i;
  logic [ADDRESS_WIDTH-1:0] im_addr_o;
  logic [DATA_WIDTH-1:0]    im_rdata_i;
  logic [DATA_WIDTH-1:0]    instr_o;
  logic [ADDRESS_WIDTH-1:0] instr_pc_o;
  logic                     instr_valid_o;

  modport master (
    input  hold_i, stall_i, redirect_i, redirect_pc_i, im_rdata_i,
    output im_addr_o, instr_o, instr_pc_o, instr_valid_o
  );

  modport slave (
    output hold_i, stall_i, redirect_i, redirect_pc_i, im_rdata_i,
    input  im_addr_o, instr_o, instr_pc_o, instr_valid_o
  );

endinterface

// File: rtl/instruction_fetch_pc_register.sv
// Fetch program counter: loads a new address, increments, or holds.
//   clk, rst   : clock, synchronous active-high reset (pc <= RESET_PC)
//   load       : take load_value (wins over inc)
//   load_value : address to load
//   inc        : advance pc by one, wrapping modulo 2**ADDRESS_WIDTH
//   pc         : current fetch address
module pc_register
  import instruction_fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [ADDRESS_WIDTH-1:0] load_value,
  input  logic                     inc,
  output logic [ADDRESS_WIDTH-1:0] pc
);

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + 1'b1;  // natural wrap 'hFF -> 'h00
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage in front of a synchronous (1-cycle read latency) instruction memory.
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : instruction_fetch_if.master
//          hold_i        loader owns memory, fetch frozen
//          stall_i       decode cannot accept, output held
//          redirect_i    branch/jump taken, redirect_pc_i is the target
//          im_addr_o     memory read address (combinational)
//          im_rdata_i    memory data for the address presented last cycle
//          instr_o / instr_pc_o / instr_valid_o  registered output to decode
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [ADDRESS_WIDTH-1:0] pend_pc;     // address whose data is on im_rdata_i now
  logic                     pend_valid;
  fetch_out_t               out_q;

  fetch_action_t            action;
  logic                     pc_load;
  logic [ADDRESS_WIDTH-1:0] pc_load_value;
  logic                     pc_inc;

  // During a stall the memory re-reads pend_pc, so its data stays put and
  // the instruction is not lost when the stall releases.
  assign bus.im_addr_o = bus.stall_i ? pend_pc : fetch_pc;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    action        = ACT_ADVANCE;
    pc_load       = 1'b0;
    pc_load_value = fetch_pc;
    pc_inc        = 1'b0;

    if (bus.hold_i)          action = ACT_HOLD;
    else if (bus.redirect_i) action = ACT_REDIRECT;
    else if (bus.stall_i)    action = ACT_STALL;

    unique case (action)
      ACT_HOLD: begin
        // Rewind to the in-flight address so the restart re-reads it from
        // the (possibly rewritten) memory.
        pc_load       = pend_valid;
        pc_load_value = pend_pc;
      end
      ACT_REDIRECT: begin
        pc_load       = 1'b1;
        pc_load_value = bus.redirect_pc_i;
      end
      ACT_STALL:   ;
      ACT_ADVANCE: pc_inc = 1'b1;
      default:     ;
    endcase
  end

  pc_register u_pc_register (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .load_value (pc_load_value),
    .inc        (pc_inc),
    .pc         (fetch_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      out_q      <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    end else begin
      unique case (action)
        ACT_HOLD: begin
          pend_valid  <= 1'b0;
          out_q.valid <= 1'b0;
        end
        ACT_REDIRECT: begin
          // Flush: the in-flight read and the shown instruction are wrong-path.
          pend_valid  <= 1'b0;
          out_q.valid <= 1'b0;
        end
        ACT_STALL: ;
        ACT_ADVANCE: begin
          pend_pc    <= fetch_pc;
          pend_valid <= 1'b1;
          out_q      <= '{instr: bus.im_rdata_i, pc: pend_pc, valid: pend_valid};
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_o       = out_q.instr;
  assign bus.instr_pc_o    = out_q.pc;
  assign bus.instr_valid_o = out_q.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous-read memory model, mem[i] = A000 + i, with a loader write port.
  logic [DATA_WIDTH-1:0]    mem [256];
  logic                     mem_we = 1'b0;
  logic [ADDRESS_WIDTH-1:0] mem_waddr = '0;
  logic [DATA_WIDTH-1:0]    mem_wdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    bus.im_rdata_i <= mem[bus.im_addr_o];
  end

  int n_asserts = 0;
  int n_fail    = 0;

  function automatic fetch_out_t exp_at(input logic [ADDRESS_WIDTH-1:0] pc);
    fetch_out_t e;
    e.instr = 16'hA000 + {8'h00, pc};
    e.pc    = pc;
    e.valid = 1'b1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input fetch_out_t exp);
    fetch_out_t obs;
    obs.instr = bus.instr_o;
    obs.pc    = bus.instr_pc_o;
    obs.valid = bus.instr_valid_o;
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed instr=%h pc=%h valid=%b, expected instr=%h pc=%h valid=%b",
             tag, obs.instr, obs.pc, obs.valid, exp.instr, exp.pc, exp.valid);
    end
  endtask

  task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    fetch_out_t held;
    bus.hold_i        = 1'b0;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;

    // 1: reset, first fetch latency, steady stream
    rst = 1'b1;
    repeat (3) step();
    chk_out("reset_out", '{instr: NOP_INSTR, pc: 8'h00, valid: 1'b0});
    chk_val("reset_addr", 16'(bus.im_addr_o), 16'h0000);
    rst = 1'b0;
    step();
    chk_val("edge1_invalid", 16'(bus.instr_valid_o), 16'h0000);
    step();
    chk_out("edge2_first", exp_at(8'h00));
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_out($sformatf("stream_%0d", k), exp_at(8'(k)));
    end

    // 2: stall for 3 cycles while pc=05 is shown
    bus.stall_i = 1'b1;
    #1;
    chk_val("stall_addr_replay", 16'(bus.im_addr_o), 16'h0006);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("stall_hold_%0d", k), exp_at(8'h05));
    end
    bus.stall_i = 1'b0;
    step();
    chk_out("stall_release", exp_at(8'h06));
    step();
    chk_out("pre_redirect", exp_at(8'h07));

    // 3: redirect to 40 while pc=07 shown
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 8'h40;
    step();
    bus.redirect_i = 1'b0;
    held = exp_at(8'h07);
    held.valid = 1'b0;
    chk_out("redirect_flush", held);
    step();
    chk_val("redirect_bubble2", 16'(bus.instr_valid_o), 16'h0000);
    step();
    chk_out("redirect_target", exp_at(8'h40));
    step();
    chk_out("redirect_target_p1", exp_at(8'h41));

    // 4: redirect together with stall, redirect wins
    bus.redirect_i    = 1'b1;
    bus.stall_i       = 1'b1;
    bus.redirect_pc_i = 8'h40;
    step();
    bus.redirect_i = 1'b0;
    bus.stall_i    = 1'b0;
    held = exp_at(8'h41);
    held.valid = 1'b0;
    chk_out("redir_stall_flush", held);
    step();
    chk_val("redir_stall_bubble2", 16'(bus.instr_valid_o), 16'h0000);
    step();
    chk_out("redir_stall_target", exp_at(8'h40));

    // 5: PC wrap FF -> 00
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 8'hFD;
    step();
    bus.redirect_i = 1'b0;
    step();
    step();
    chk_out("wrap_fd", exp_at(8'hFD));
    step();
    chk_out("wrap_fe", exp_at(8'hFE));
    step();
    chk_out("wrap_ff", exp_at(8'hFF));
    step();
    chk_out("wrap_00", exp_at(8'h00));
    step();
    chk_out("wrap_01", exp_at(8'h01));

    // 6: hold at pc=10, loader rewrites mem[11], redirect during hold ignored
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 8'h0E;
    step();
    bus.redirect_i = 1'b0;
    step();
    step();
    chk_out("hold_pre_0e", exp_at(8'h0E));
    step();
    step();
    chk_out("hold_pre_10", exp_at(8'h10));
    bus.hold_i = 1'b1;
    mem_we     = 1'b1;
    mem_waddr  = 8'h11;
    mem_wdata  = 16'hBEEF;
    step();
    mem_we = 1'b0;
    chk_val("hold_invalid_0", 16'(bus.instr_valid_o), 16'h0000);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 8'h80;
    step();
    bus.redirect_i = 1'b0;
    chk_val("hold_invalid_1", 16'(bus.instr_valid_o), 16'h0000);
    step();
    step();
    chk_val("hold_invalid_3", 16'(bus.instr_valid_o), 16'h0000);
    bus.hold_i = 1'b0;
    step();
    chk_val("hold_restart_bubble", 16'(bus.instr_valid_o), 16'h0000);
    step();
    chk_out("hold_beef", '{instr: 16'hBEEF, pc: 8'h11, valid: 1'b1});
    step();
    chk_out("hold_after", exp_at(8'h12));

    // Reset in the middle of a stall discards everything
    bus.stall_i = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk_out("rst_mid_stall", '{instr: NOP_INSTR, pc: 8'h00, valid: 1'b0});
    rst = 1'b0;
    bus.stall_i = 1'b0;
    step();
    chk_val("rst_mid_stall_bubble", 16'(bus.instr_valid_o), 16'h0000);
    step();
    chk_out("rst_mid_stall_first", exp_at(8'h00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
